// File: rtl/mem_port_arbiter.sv
// Two-master round-robin arbiter in front of a single Dcache port.
// One transaction in flight; loads may time out in WAIT.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req_i,
  input  logic        m0_rw_i,
  input  logic [31:0] m0_addr_i,
  input  logic [1:0]  m0_width_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_gnt_o,
  output logic        m0_done_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic        m1_rw_i,
  input  logic [31:0] m1_addr_i,
  input  logic [1:0]  m1_width_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_gnt_o,
  output logic        m1_done_o,
  output logic [31:0] m1_rdata_o,
  output logic        d_req_o,
  output logic        d_rw_o,
  output logic [31:0] d_addr_o,
  output logic [1:0]  d_width_o,
  output logic [31:0] d_wdata_o,
  input  logic        d_ready_i,
  input  logic        d_rvalid_i,
  input  logic [31:0] d_rdata_i,
  output logic        busy_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q;
  state_t      state_d;
  logic        ptr_q;
  logic        own_q;
  logic [7:0]  cnt_q;
  logic        gnt0;
  logic        gnt1;
  logic        take;
  logic        accept;
  logic        rx;
  logic        tmo;
  logic        done_ev;

  // ptr_q names the last-granted master; on contention the other one wins
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE) begin
      unique case (1'b1)
        m0_req_i && !m1_req_i: gnt0 = 1'b1;
        !m0_req_i && m1_req_i: gnt1 = 1'b1;
        m0_req_i && m1_req_i: begin
          gnt0 = ptr_q;
          gnt1 = !ptr_q;
        end
        default: ;
      endcase
    end
  end

  assign m0_gnt_o = gnt0;
  assign m1_gnt_o = gnt1;
  assign busy_o   = (state_q != IDLE);

  assign take    = gnt0 | gnt1;
  assign accept  = (state_q == REQ) && d_ready_i;
  assign rx      = (state_q == WAIT) && d_rvalid_i;
  assign tmo     = (state_q == WAIT) && !d_rvalid_i
                   && (cnt_q == TMO_LAST);
  assign done_ev = (accept && d_rw_o) | rx | tmo;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (take) state_d = REQ;
      REQ:  if (d_ready_i) state_d = d_rw_o ? IDLE : WAIT;
      WAIT: if (rx || tmo) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      ptr_q      <= 1'b1;
      own_q      <= 1'b0;
      cnt_q      <= '0;
      d_req_o    <= 1'b0;
      d_rw_o     <= 1'b0;
      d_addr_o   <= '0;
      d_width_o  <= '0;
      d_wdata_o  <= '0;
      m0_done_o  <= 1'b0;
      m1_done_o  <= 1'b0;
      m0_rdata_o <= '0;
      m1_rdata_o <= '0;
      err_o      <= 1'b0;
    end else begin
      m0_done_o <= 1'b0;
      m1_done_o <= 1'b0;
      err_o     <= tmo;
      if (take) begin
        d_req_o   <= 1'b1;
        d_rw_o    <= gnt1 ? m1_rw_i    : m0_rw_i;
        d_addr_o  <= gnt1 ? m1_addr_i  : m0_addr_i;
        d_width_o <= gnt1 ? m1_width_i : m0_width_i;
        d_wdata_o <= gnt1 ? m1_wdata_i : m0_wdata_i;
        own_q     <= gnt1;
        ptr_q     <= gnt1;
      end
      if (accept) begin
        d_req_o <= 1'b0;
        cnt_q   <= '0;
      end else if (state_q == WAIT) begin
        cnt_q <= (rx || tmo) ? 8'd0 : cnt_q + 8'd1;
      end
      if (done_ev) begin
        m0_done_o <= !own_q;
        m1_done_o <= own_q;
      end
      // a timed-out load returns zero data
      if (rx || tmo) begin
        if (own_q) m1_rdata_o <= rx ? d_rdata_i : 32'd0;
        else       m0_rdata_o <= rx ? d_rdata_i : 32'd0;
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, sets the maximum WAIT-state cycles before a transaction is aborted (legal range 1..255).
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous reset, active-high (asserted = 1); the polarity and synchronicity are fixed, the name is the codebase's.
REQ-004 mX_req_i  input  1  request from master X (X = 0, 1); held until mX_gnt_o.
REQ-005 mX_rw_i  input  1  1 = store, 0 = load.
REQ-006 mX_addr_i  input  32  byte address.
REQ-007 mX_width_i  input  2  access width code, passed through unchanged.
REQ-008 mX_wdata_i  input  32  store data.
REQ-009 mX_gnt_o  output  1  combinational, 1-cycle accept of master X's request.
REQ-010 mX_done_o  output  1  registered, 1-cycle completion pulse to master X.
REQ-011 mX_rdata_o  output  32  registered load data, valid with mX_done_o.
REQ-012 d_req_o, d_rw_o, d_addr_o[31:0], d_width_o[1:0], d_wdata_o[31:0]  output  Dcache request bundle, all driven from internal registers.
REQ-013 d_ready_i  input  1  Dcache accepts d_req_o this cycle.
REQ-014 d_rvalid_i, d_rdata_i[31:0]  input  load response from the Dcache.
REQ-015 busy_o  output  1  high when the state is not IDLE.
REQ-016 err_o  output  1  registered, 1-cycle pulse on a timeout.

Function
REQ-017 FSM states SHALL be IDLE, REQ and WAIT, with exactly one transaction in flight.
REQ-018 IDLE: if any mX_req_i is high, the block grants exactly one master, latches its rw/addr/width/wdata, records the owner, and moves to REQ on the next edge.
REQ-019 Arbitration SHALL be round-robin through a 1-bit last-grant pointer.
- Both requesting: the master that is not the last-granted one wins.
- Single requester: that master wins, and the pointer updates to it.
REQ-020 mX_gnt_o SHALL be high only in IDLE, and only for the winning master.
REQ-021 REQ: d_req_o = 1 with the latched fields; these SHALL hold stable until d_ready_i.
REQ-022 REQ with d_ready_i and a store: done pulse to the owner on the next cycle, then return to IDLE.
REQ-023 REQ with d_ready_i and a load: go to WAIT and clear the timeout counter.
REQ-024 d_rvalid_i SHALL be ignored outside WAIT.
REQ-025 WAIT with d_rvalid_i: latch d_rdata_i into the owner's mX_rdata_o, pulse the owner's mX_done_o on the next cycle, then return to IDLE.
REQ-026 WAIT without d_rvalid_i: the 8-bit counter increments. When it reaches TIMEOUT:
- err_o and the owner's mX_done_o pulse on the next cycle;
- mX_rdata_o = 0;
- state returns to IDLE.
REQ-027 d_rvalid_i in the same cycle as the timeout SHALL take precedence: normal completion, no err_o.
REQ-028 Minimum load latency: grant at cycle N, d_req_o in N+1, d_ready_i in N+1, d_rvalid_i in N+2, mX_done_o in N+3.
REQ-029 A master dropping mX_req_i after its grant SHALL NOT abort the transaction.
REQ-030 The non-owner's mX_rdata_o SHALL hold its previous value, and the non-owner's mX_done_o SHALL stay 0.
REQ-031 IDLE re-entry with requests pending: a new grant is possible in the first IDLE cycle (one idle cycle between transactions).

Reset
REQ-032 On rst_n = 1, at any time including mid-transaction, the following SHALL clear asynchronously:
- state = IDLE, pointer = 1 (master 0 wins first), counter = 0;
- d_req_o, d_rw_o = 0; d_addr_o, d_width_o, d_wdata_o = 0;
- mX_done_o, mX_rdata_o, err_o, busy_o = 0.
REQ-033 An in-flight transaction SHALL be dropped with no done pulse, and a late d_rvalid_i after reset SHALL be ignored.

Verification
REQ-034 Load: m0 load to 0x100, d_ready_i = 1, d_rvalid_i one cycle later with 0xDEADBEEF -> m0_done_o at N+3 with m0_rdata_o = 0xDEADBEEF; m1 outputs unchanged.
REQ-035 Contention: m0 and m1 request continuously after reset -> grants go m0, m1, m0, m1; each d_addr_o matches its owner.
REQ-036 Backpressure: d_ready_i low for 5 cycles in REQ -> d_req_o and the bundle stay stable for 5 cycles; the store done pulse follows the accept.
REQ-037 Timeout with TIMEOUT = 4: no d_rvalid_i -> err_o and done pulse after 4 WAIT cycles, rdata = 0, busy_o falls; a late d_rvalid_i is ignored.
REQ-038 Simultaneous events: d_rvalid_i on the timeout cycle -> data delivered, err_o = 0.
REQ-039 Reset mid-WAIT: rst_n asserted in WAIT -> all outputs 0 immediately; after release, m0 wins first.
